// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter. There are two request and response channels.
// The slave modport is the arbiter. The master modport is the requester pair.
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int FUN_W  = 4
);
  logic              REQ0_valid;
  logic              REQ0_ready;
  logic [DATA_W-1:0] REQ0_srcA;
  logic [DATA_W-1:0] REQ0_srcB;
  logic [FUN_W-1:0]  REQ0_fun;
  logic              REQ1_valid;
  logic              REQ1_ready;
  logic [DATA_W-1:0] REQ1_srcA;
  logic [DATA_W-1:0] REQ1_srcB;
  logic [FUN_W-1:0]  REQ1_fun;
  logic              RSP0_valid;
  logic              RSP0_ready;
  logic [DATA_W-1:0] RSP0_data;
  logic              RSP0_err;
  logic              RSP1_valid;
  logic              RSP1_ready;
  logic [DATA_W-1:0] RSP1_data;
  logic              RSP1_err;

  modport master (
    output REQ0_valid, REQ0_srcA, REQ0_srcB, REQ0_fun, RSP0_ready,
    output REQ1_valid, REQ1_srcA, REQ1_srcB, REQ1_fun, RSP1_ready,
    input  REQ0_ready, RSP0_valid, RSP0_data, RSP0_err,
    input  REQ1_ready, RSP1_valid, RSP1_data, RSP1_err
  );

  modport slave (
    input  REQ0_valid, REQ0_srcA, REQ0_srcB, REQ0_fun, RSP0_ready,
    input  REQ1_valid, REQ1_srcA, REQ1_srcB, REQ1_fun, RSP1_ready,
    output REQ0_ready, RSP0_valid, RSP0_data, RSP0_err,
    output REQ1_ready, RSP1_valid, RSP1_data, RSP1_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters. Each response is registered one cycle later.
// Optional grant/conflict statistics counters are enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int FUN_W  = 4
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST_N,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] ALU_srcA,
  output logic [DATA_W-1:0] ALU_srcB,
  output logic [FUN_W-1:0]  ALU_fun,
  input  logic [DATA_W-1:0] ALU_result
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic              STATS_CLR,
  output logic [CNT_W-1:0]  GNT0_CNT,
  output logic [CNT_W-1:0]  GNT1_CNT,
  output logic [CNT_W-1:0]  CONFLICT_CNT
`endif
);

  typedef enum logic {PRI_REQ0, PRI_REQ1} rr_e;

  rr_e               r_rr, w_rr_nxt;
  logic              r_rsp0_valid, r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp0_data, r_rsp1_data;
  logic              r_rsp0_err, r_rsp1_err;
  logic              w_elig0, w_elig1, w_gnt0, w_gnt1, w_illegal;

  function automatic logic fun_illegal(input logic [FUN_W-1:0] f);
    case (f)
      4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0101,
      4'b0001, 4'b1101, 4'b0010, 4'b0011, 4'b1001: fun_illegal = 1'b0;
      default:                                     fun_illegal = 1'b1;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_rr <= PRI_REQ0;
    else        r_rr <= w_rr_nxt;
  end

  // A pending response only blocks its requester if that response is not popped this cycle.
  always_comb begin
    w_elig0  = bus.REQ0_valid && (!r_rsp0_valid || bus.RSP0_ready);
    w_elig1  = bus.REQ1_valid && (!r_rsp1_valid || bus.RSP1_ready);
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_rr_nxt = r_rr;
    ALU_srcA = '0;
    ALU_srcB = '0;
    ALU_fun  = '0;
    if (w_elig0 && w_elig1) begin
      if (r_rr == PRI_REQ0) w_gnt0 = 1'b1;
      else                  w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = w_elig0;
      w_gnt1 = w_elig1;
    end
    if (w_gnt0) begin
      w_rr_nxt = PRI_REQ1;
      ALU_srcA = bus.REQ0_srcA;
      ALU_srcB = bus.REQ0_srcB;
      ALU_fun  = bus.REQ0_fun;
    end else if (w_gnt1) begin
      w_rr_nxt = PRI_REQ0;
      ALU_srcA = bus.REQ1_srcA;
      ALU_srcB = bus.REQ1_srcB;
      ALU_fun  = bus.REQ1_fun;
    end
    w_illegal = fun_illegal(ALU_fun);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
      r_rsp1_err   <= 1'b0;
    end else begin
      if (w_gnt0) begin
        r_rsp0_valid <= 1'b1;
        r_rsp0_data  <= ALU_result;
        r_rsp0_err   <= w_illegal;
      end else if (bus.RSP0_ready) begin
        r_rsp0_valid <= 1'b0;
      end
      if (w_gnt1) begin
        r_rsp1_valid <= 1'b1;
        r_rsp1_data  <= ALU_result;
        r_rsp1_err   <= w_illegal;
      end else if (bus.RSP1_ready) begin
        r_rsp1_valid <= 1'b0;
      end
    end
  end

  assign bus.REQ0_ready = w_gnt0;
  assign bus.REQ1_ready = w_gnt1;
  assign bus.RSP0_valid = r_rsp0_valid;
  assign bus.RSP0_data  = r_rsp0_data;
  assign bus.RSP0_err   = r_rsp0_err;
  assign bus.RSP1_valid = r_rsp1_valid;
  assign bus.RSP1_data  = r_rsp1_data;
  assign bus.RSP1_err   = r_rsp1_err;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_gnt0_cnt, r_gnt1_cnt, r_conflict_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_gnt0_cnt     <= '0;
      r_gnt1_cnt     <= '0;
      r_conflict_cnt <= '0;
    end else if (STATS_CLR) begin
      r_gnt0_cnt     <= '0;
      r_gnt1_cnt     <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_gnt0 && (r_gnt0_cnt != '1))             r_gnt0_cnt     <= r_gnt0_cnt + 1'b1;
      if (w_gnt1 && (r_gnt1_cnt != '1))             r_gnt1_cnt     <= r_gnt1_cnt + 1'b1;
      if (w_elig0 && w_elig1 && (r_conflict_cnt != '1)) r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign GNT0_CNT     = r_gnt0_cnt;
  assign GNT1_CNT     = r_gnt1_cnt;
  assign CONFLICT_CNT = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner sequences and randomized traffic.
// An external ALU model and a requester-level reference model are used. Statistics checks run when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] alu_srcA, alu_srcB, alu_result;
  logic [3:0]  alu_fun;
`ifdef ALU_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] gnt0_cnt, gnt1_cnt, conflict_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  alu_arbiter_if #(.DATA_W(32), .FUN_W(4)) bus ();

  alu_arbiter #(
    .DATA_W(32),
    .FUN_W (4)
`ifdef ALU_ARB_STATS_EN
    ,
    .CNT_W (16)
`endif
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .ALU_srcA  (alu_srcA),
    .ALU_srcB  (alu_srcB),
    .ALU_fun   (alu_fun),
    .ALU_result(alu_result)
`ifdef ALU_ARB_STATS_EN
    ,
    .STATS_CLR   (stats_clr),
    .GNT0_CNT    (gnt0_cnt),
    .GNT1_CNT    (gnt1_cnt),
    .CONFLICT_CNT(conflict_cnt)
`endif
  );

  int legal_codes[11] = '{0, 8, 7, 6, 4, 5, 1, 13, 2, 3, 9};

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    case (f)
      4'd0:    alu_ref = a + b;
      4'd8:    alu_ref = a - b;
      4'd7:    alu_ref = a & b;
      4'd6:    alu_ref = a | b;
      4'd4:    alu_ref = a ^ b;
      4'd5:    alu_ref = a >> b[4:0];
      4'd1:    alu_ref = a << b[4:0];
      4'd13:   alu_ref = 32'($signed(a) >>> b[4:0]);
      4'd2:    alu_ref = {31'd0, $signed(a) < $signed(b)};
      4'd3:    alu_ref = {31'd0, a < b};
      4'd9:    alu_ref = b;
      default: alu_ref = 32'hdeadbeef;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_srcA, alu_srcB, alu_fun);

  function automatic bit is_legal(input logic [3:0] f);
    is_legal = 1'b0;
    foreach (legal_codes[k]) if (int'(f) == legal_codes[k]) is_legal = 1'b1;
  endfunction

  // Requester stimulus, indexed by requester number
  bit          in_v[2];
  logic [31:0] in_a[2], in_b[2];
  logic [3:0]  in_f[2];
  bit          in_rr[2];

  // Reference model: outstanding response slot per requester and the tie-break winner
  bit          m_v[2];
  logic [31:0] m_d[2];
  bit          m_e[2];
  int          m_pri;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input bit rr);
    in_v[i] = v; in_a[i] = a; in_b[i] = b; in_f[i] = f; in_rr[i] = rr;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_d[i] = '0; m_e[i] = 1'b0;
    end
    m_pri = 0;
  endtask

  function automatic logic rsp_v(input int i);
    rsp_v = (i == 0) ? bus.RSP0_valid : bus.RSP1_valid;
  endfunction
  function automatic logic [31:0] rsp_d(input int i);
    rsp_d = (i == 0) ? bus.RSP0_data : bus.RSP1_data;
  endfunction
  function automatic logic rsp_e(input int i);
    rsp_e = (i == 0) ? bus.RSP0_err : bus.RSP1_err;
  endfunction

  task automatic drive();
    bus.REQ0_valid = in_v[0]; bus.REQ0_srcA = in_a[0]; bus.REQ0_srcB = in_b[0];
    bus.REQ0_fun = in_f[0]; bus.RSP0_ready = in_rr[0];
    bus.REQ1_valid = in_v[1]; bus.REQ1_srcA = in_a[1]; bus.REQ1_srcB = in_b[1];
    bus.REQ1_fun = in_f[1]; bus.RSP1_ready = in_rr[1];
  endtask

  // One clock: check registered responses, apply stimulus, check grant/ALU drive, advance the model.
  task automatic cycle();
    int win;
    bit e[2];
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rsp%0d_valid", i), 32'(rsp_v(i)), 32'(m_v[i]));
      chk($sformatf("rsp%0d_data", i), rsp_d(i), m_d[i]);
      chk($sformatf("rsp%0d_err", i), 32'(rsp_e(i)), 32'(m_e[i]));
    end
    drive();
    #1;
    for (int i = 0; i < 2; i++) e[i] = in_v[i] && (!m_v[i] || in_rr[i]);
    if (e[0] && e[1]) win = m_pri;
    else if (e[0])    win = 0;
    else if (e[1])    win = 1;
    else              win = -1;
    chk("req0_ready", 32'(bus.REQ0_ready), 32'(win == 0));
    chk("req1_ready", 32'(bus.REQ1_ready), 32'(win == 1));
    chk("alu_srcA", alu_srcA, (win < 0) ? 32'd0 : in_a[win]);
    chk("alu_srcB", alu_srcB, (win < 0) ? 32'd0 : in_b[win]);
    chk("alu_fun", 32'(alu_fun), (win < 0) ? 32'd0 : 32'(in_f[win]));
    for (int i = 0; i < 2; i++) begin
      if (win == i) begin
        m_v[i] = 1'b1;
        m_d[i] = alu_ref(in_a[i], in_b[i], in_f[i]);
        m_e[i] = !is_legal(in_f[i]);
      end else if (in_rr[i]) begin
        m_v[i] = 1'b0;
      end
    end
    if (win >= 0) m_pri = 1 - win;
  endtask

  typedef struct {
    bit v0; logic [31:0] a0, b0; logic [3:0] f0; bit r0;
    bit v1; logic [31:0] a1, b1; logic [3:0] f1; bit r1;
    bit xs_v0; logic [31:0] xs_d0; bit xs_e0;
    bit xs_v1; logic [31:0] xs_d1; bit xs_e1;
    bit x_rdy0, x_rdy1; logic [3:0] x_fun;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // xs_* are the registered responses visible during the row, before its edge
    tbl[0] = '{1, 5, 3, 4'h0, 1,  0, 0, 0, 4'h0, 1,  0, 0, 0,  0, 0, 0,  1, 0, 4'h0};
    tbl[1] = '{1, 20, 4, 4'h8, 1,  1, 10, 3, 4'h8, 1,  1, 8, 0,  0, 0, 0,  0, 1, 4'h8};
    tbl[2] = '{1, 20, 4, 4'h7, 1,  1, 10, 3, 4'h6, 1,  0, 8, 0,  1, 7, 0,  1, 0, 4'h7};
    tbl[3] = '{1, 20, 4, 4'h4, 1,  1, 10, 3, 4'h0, 1,  1, 4, 0,  0, 7, 0,  0, 1, 4'h0};
    tbl[4] = '{0, 0, 0, 4'h0, 1,  0, 0, 0, 4'h0, 1,  0, 4, 0,  1, 13, 0,  0, 0, 4'h0};
    tbl[5] = '{0, 0, 0, 4'h0, 1,  1, 1, 2, 4'hf, 1,  0, 4, 0,  0, 13, 0,  0, 1, 4'hf};
    tbl[6] = '{0, 0, 0, 4'h0, 1,  0, 0, 0, 4'h0, 0,  0, 4, 0,  1, 32'hdeadbeef, 1,  0, 0, 4'h0};
    tbl[7] = '{0, 0, 0, 4'h0, 1,  0, 0, 0, 4'h0, 1,  0, 4, 0,  1, 32'hdeadbeef, 1,  0, 0, 4'h0};
    tbl[8] = '{1, 32'hffffffff, 1, 4'h0, 1,  0, 0, 0, 4'h0, 1,  0, 4, 0,  0, 32'hdeadbeef, 1,  1, 0, 4'h0};

    for (int i = 0; i < 2; i++) set_req(i, 0, 0, 0, 4'h0, 0);
    drive();
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (tbl[r]) begin
      set_req(0, tbl[r].v0, tbl[r].a0, tbl[r].b0, tbl[r].f0, tbl[r].r0);
      set_req(1, tbl[r].v1, tbl[r].a1, tbl[r].b1, tbl[r].f1, tbl[r].r1);
      cycle();
      chk($sformatf("tbl%0d_rsp0_valid", r), 32'(bus.RSP0_valid), 32'(tbl[r].xs_v0));
      chk($sformatf("tbl%0d_rsp0_data", r), bus.RSP0_data, tbl[r].xs_d0);
      chk($sformatf("tbl%0d_rsp0_err", r), 32'(bus.RSP0_err), 32'(tbl[r].xs_e0));
      chk($sformatf("tbl%0d_rsp1_valid", r), 32'(bus.RSP1_valid), 32'(tbl[r].xs_v1));
      chk($sformatf("tbl%0d_rsp1_data", r), bus.RSP1_data, tbl[r].xs_d1);
      chk($sformatf("tbl%0d_rsp1_err", r), 32'(bus.RSP1_err), 32'(tbl[r].xs_e1));
      chk($sformatf("tbl%0d_req0_ready", r), 32'(bus.REQ0_ready), 32'(tbl[r].x_rdy0));
      chk($sformatf("tbl%0d_req1_ready", r), 32'(bus.REQ1_ready), 32'(tbl[r].x_rdy1));
      chk($sformatf("tbl%0d_alu_fun", r), 32'(alu_fun), 32'(tbl[r].x_fun));
    end

    // Blocked requester with an unconsumed response, then a pop with a same-cycle refill
    set_req(0, 1, 9, 1, 4'h8, 0);
    set_req(1, 0, 0, 0, 4'h0, 1);
    repeat (2) begin
      cycle();
      chk("hold_req0_ready", 32'(bus.REQ0_ready), 32'd0);
      chk("hold_rsp0_valid", 32'(bus.RSP0_valid), 32'd1);
      chk("hold_rsp0_data", bus.RSP0_data, 32'd0);
    end
    set_req(0, 1, 9, 1, 4'h8, 1);
    cycle();
    chk("refill_req0_ready", 32'(bus.REQ0_ready), 32'd1);
    set_req(0, 0, 0, 0, 4'h0, 0);
    cycle();
    chk("refill_rsp0_valid", 32'(bus.RSP0_valid), 32'd1);
    chk("refill_rsp0_data", bus.RSP0_data, 32'd8);
    set_req(0, 0, 0, 0, 4'h0, 1);
    cycle();

    // Asynchronous reset with both responses pending
    set_req(0, 1, 1, 1, 4'h0, 0);
    set_req(1, 1, 2, 2, 4'h0, 0);
    repeat (2) cycle();
    set_req(0, 0, 0, 0, 4'h0, 0);
    set_req(1, 0, 0, 0, 4'h0, 0);
    cycle();
    chk("pre_rst_rsp0_valid", 32'(bus.RSP0_valid), 32'd1);
    chk("pre_rst_rsp1_valid", 32'(bus.RSP1_valid), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_rsp0_valid", 32'(bus.RSP0_valid), 32'd0);
    chk("async_rst_rsp1_valid", 32'(bus.RSP1_valid), 32'd0);
    chk("async_rst_rsp1_data", bus.RSP1_data, 32'd0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    set_req(0, 1, 3, 4, 4'h0, 1);
    set_req(1, 1, 5, 6, 4'h0, 1);
    cycle();
    chk("post_rst_req0_ready", 32'(bus.REQ0_ready), 32'd1);
    chk("post_rst_req1_ready", 32'(bus.REQ1_ready), 32'd0);

`ifdef ALU_ARB_STATS_EN
    set_req(0, 0, 0, 0, 4'h0, 1);
    set_req(1, 0, 0, 0, 4'h0, 1);
    stats_clr = 1'b1;
    cycle();
    stats_clr = 1'b0;
    set_req(0, 1, 7, 1, 4'h0, 1);
    set_req(1, 1, 7, 2, 4'h8, 1);
    repeat (4) cycle();
    set_req(0, 0, 0, 0, 4'h0, 1);
    repeat (2) cycle();
    set_req(0, 1, 7, 1, 4'h0, 1);
    stats_clr = 1'b1;
    cycle();
    chk("stats_gnt0", 32'(gnt0_cnt), 32'd2);
    chk("stats_gnt1", 32'(gnt1_cnt), 32'd4);
    chk("stats_conflict", 32'(conflict_cnt), 32'd4);
    stats_clr = 1'b0;
    set_req(0, 0, 0, 0, 4'h0, 1);
    set_req(1, 0, 0, 0, 4'h0, 1);
    cycle();
    chk("stats_clr_gnt0", 32'(gnt0_cnt), 32'd0);
    chk("stats_clr_gnt1", 32'(gnt1_cnt), 32'd0);
    chk("stats_clr_conflict", 32'(conflict_cnt), 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        logic [3:0] f;
        if ($urandom_range(0, 9) == 0) f = 4'($urandom_range(0, 15));
        else                           f = 4'(legal_codes[$urandom_range(0, 10)]);
        set_req(i, $urandom_range(0, 9) < 6, $urandom, 32'($urandom_range(0, 40)), f,
                $urandom_range(0, 9) < 7);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
